mips_muldiv: RTL and testbench

MIPS_MULDIV -- requirements
Module: mips_muldiv

---
 rtl/mips_muldiv.sv | 189 ++++++++++++++++++
 tb/tb_mips_muldiv.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv.sv
// MIPS HI/LO multiply/divide unit: one iteration per cycle over 32 cycles.
// Ops: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Define MIPS_MULDIV_DIV_EN to
// build the divider; without it, divide requests are ignored.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_1,
  input  logic [WIDTH-1:0] src_2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned DW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;      // multiplicand or divisor magnitude
  logic [DW-1:0]      p_q, p_d;      // product, or {remainder, quotient}
  logic               res_neg_q, res_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef MIPS_MULDIV_DIV_EN
  logic               is_div_q, is_div_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div_zero_q, div_zero_d;
`endif

  // Operand sign handling for signed ops (op[0]=0)
  logic             s1_neg, s2_neg, op_ok;
  logic [WIDTH-1:0] s1_mag, s2_mag;
  assign s1_neg = ~op[0] & src_1[WIDTH-1];
  assign s2_neg = ~op[0] & src_2[WIDTH-1];
  assign s1_mag = s1_neg ? -src_1 : src_1;
  assign s2_mag = s2_neg ? -src_2 : src_2;
`ifdef MIPS_MULDIV_DIV_EN
  assign op_ok  = 1'b1;
`else
  assign op_ok  = ~op[1];
`endif

  // Shift-add multiply step: add multiplicand on LSB, shift right
  logic [WIDTH:0]  mul_sum;
  logic [DW-1:0]   mul_next, mul_res;
  assign mul_sum  = {1'b0, p_q[DW-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, p_q[WIDTH-1:1]};
  assign mul_res  = res_neg_q ? -p_q : p_q;

`ifdef MIPS_MULDIV_DIV_EN
  // Restoring divide step: shift in next dividend bit, subtract if it fits
  logic [WIDTH:0]   div_tmp, div_diff;
  logic             div_ge;
  logic [DW-1:0]    div_next;
  logic [WIDTH-1:0] quo, rem;
  assign div_tmp  = {p_q[DW-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff = div_tmp - {1'b0, a_q};
  assign div_ge   = (div_tmp >= {1'b0, a_q});
  assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]),
                     p_q[WIDTH-2:0], div_ge};
  assign quo      = p_q[WIDTH-1:0];
  assign rem      = p_q[DW-1:WIDTH];
`endif

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    p_d       = p_q;
    res_neg_d = res_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
    is_div_d   = is_div_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_ok) begin
            state_d   = S_CALC;
            cnt_d     = '0;
            busy_d    = 1'b1;
            res_neg_d = s1_neg ^ s2_neg;
            a_d       = s1_mag;
            p_d       = {{WIDTH{1'b0}}, s2_mag};
`ifdef MIPS_MULDIV_DIV_EN
            is_div_d   = op[1];
            rem_neg_d  = s1_neg;
            div_zero_d = (src_2 == '0);
            if (op[1]) begin
              a_d = s2_mag;
              p_d = {{WIDTH{1'b0}}, s1_mag};
            end
`endif
          end
        end else begin
          if (mthi) hi_d = src_1;
          if (mtlo) lo_d = src_1;
        end
      end
      S_CALC: begin
        p_d   = mul_next;
`ifdef MIPS_MULDIV_DIV_EN
        if (is_div_q) p_d = div_next;
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        {hi_d, lo_d} = mul_res;
`ifdef MIPS_MULDIV_DIV_EN
        if (is_div_q) begin
          lo_d = (res_neg_q && !div_zero_q) ? -quo : quo;
          hi_d = rem_neg_q ? -rem : rem;
        end
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      p_q        <= '0;
      res_neg_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
      is_div_q   <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      p_q        <= p_d;
      res_neg_q  <= res_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MIPS_MULDIV_DIV_EN
      is_div_q   <= is_div_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed self-checking bench for mips_muldiv (divide tests follow MIPS_MULDIV_DIV_EN).
module tb_mips_muldiv;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_1;
  logic [31:0] src_2;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int nvec = 0;
  int nerr = 0;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src_1(src_1), .src_2(src_2), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a start for one cycle from the current negedge, then scramble operands
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_1 = a; src_2 = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); src_1 = $urandom; src_2 = $urandom;
  endtask

  // Count cycles until done; -1 if it never arrives
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; op = 2'b01; mthi = 1'b1; mtlo = 1'b1;
    src_1 = 32'hDEADBEEF; src_2 = 32'h3;
    repeat (3) @(negedge clk);
    nvec++; if (hi !== 32'h0 || lo !== 32'h0) begin nerr++;
      $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo); end
    nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++;
      $display("FAIL reset_flags: busy=%b done=%b required 0/0", busy, done); end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    int lat;
    src_1 = 32'd6; mthi = 1'b1; @(negedge clk); mthi = 1'b0;
    nvec++; if (hi !== 32'd6) begin nerr++; $display("FAIL mthi: hi=%h required 6", hi); end
    src_1 = 32'd6; mtlo = 1'b1; @(negedge clk); mtlo = 1'b0;
    nvec++; if (lo !== 32'd6) begin nerr++; $display("FAIL mtlo: lo=%h required 6", lo); end
    src_1 = 32'h77; mthi = 1'b1; mtlo = 1'b1; @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    nvec++; if (hi !== 32'h77 || lo !== 32'h77) begin nerr++;
      $display("FAIL mthi_mtlo_both: hi=%h lo=%h required 77/77", hi, lo); end
    // start wins over mthi/mtlo in the same cycle
    mthi = 1'b1; mtlo = 1'b1;
    issue(2'b01, 32'd2, 32'd3);
    mthi = 1'b0; mtlo = 1'b0;
    nvec++; if (hi !== 32'h77 || lo !== 32'h77 || busy !== 1'b1) begin nerr++;
      $display("FAIL start_priority: hi=%h lo=%h busy=%b required 77/77/1", hi, lo, busy); end
    wait_done(lat);
    nvec++; if (lat !== 33 || hi !== 32'h0 || lo !== 32'h6) begin nerr++;
      $display("FAIL start_priority_res: lat=%0d hi=%h lo=%h required 33/0/6", lat, hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_multiply();
    logic [1:0]  vop [6] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    logic [31:0] va  [6] = '{32'h11111111, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] vb  [6] = '{32'h00000088, 32'h00000005, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
    logic [31:0] eh  [6] = '{32'h00000009, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFE, 32'h00000000, 32'h00000000};
    logic [31:0] el  [6] = '{32'h11111108, 32'hFFFFFFF1, 32'h00000000, 32'h00000001, 32'h00000001, 32'hFFFFFFFE};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(vop[i], va[i], vb[i]);
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL mul%0d_busy: busy=%b required 1", i, busy); end
      wait_done(lat);
      nvec++; if (lat !== 33) begin nerr++; $display("FAIL mul%0d_latency: %0d required 33", i, lat); end
      nvec++; if (hi !== eh[i] || lo !== el[i]) begin nerr++;
        $display("FAIL mul%0d_result: hi=%h lo=%h required %h/%h", i, hi, lo, eh[i], el[i]); end
      @(negedge clk);
      nvec++; if (done !== 1'b0 || busy !== 1'b0) begin nerr++;
        $display("FAIL mul%0d_pulse: done=%b busy=%b required 0/0", i, done, busy); end
    end
  endtask

`ifdef MIPS_MULDIV_DIV_EN
  task automatic test_divide();
    logic [1:0]  vop [7] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
    logic [31:0] va  [7] = '{32'h11111111, 32'hFFFFFFF9, 32'h00000007, 32'h0000000A, 32'h80000000, 32'hFFFFFFF6, 32'd100};
    logic [31:0] vb  [7] = '{32'h00000088, 32'h00000002, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'd7};
    logic [31:0] eh  [7] = '{32'h00000011, 32'hFFFFFFFF, 32'h00000001, 32'h0000000A, 32'h00000000, 32'hFFFFFFF6, 32'd2};
    logic [31:0] el  [7] = '{32'h00202020, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd14};
    int lat;
    for (int i = 0; i < 7; i++) begin
      issue(vop[i], va[i], vb[i]);
      wait_done(lat);
      nvec++; if (lat !== 33) begin nerr++; $display("FAIL div%0d_latency: %0d required 33", i, lat); end
      nvec++; if (hi !== eh[i] || lo !== el[i]) begin nerr++;
        $display("FAIL div%0d_result: hi=%h lo=%h required %h/%h", i, hi, lo, eh[i], el[i]); end
      @(negedge clk);
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL div%0d_pulse: done=%b required 0", i, done); end
    end
  endtask
`else
  task automatic test_div_disabled();
    bit saw_done = 1'b0;
    src_1 = 32'hAAAA0000; mthi = 1'b1; @(negedge clk); mthi = 1'b0;
    src_1 = 32'h00005555; mtlo = 1'b1; @(negedge clk); mtlo = 1'b0;
    issue(2'b11, 32'h11111111, 32'h88);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL divdis_busy: busy=%b required 0", busy); end
    issue(2'b10, 32'hFFFFFFF9, 32'h2);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    nvec++; if (saw_done !== 1'b0) begin nerr++; $display("FAIL divdis_activity: seen=%b required 0", saw_done); end
    nvec++; if (hi !== 32'hAAAA0000 || lo !== 32'h00005555) begin nerr++;
      $display("FAIL divdis_hilo: hi=%h lo=%h required aaaa0000/00005555", hi, lo); end
  endtask
`endif

  task automatic test_busy_ignore();
    logic [1:0]  o;
    logic [31:0] ehi, elo;
    int lat;
`ifdef MIPS_MULDIV_DIV_EN
    o = 2'b11; ehi = 32'h00000011; elo = 32'h00202020;
`else
    o = 2'b01; ehi = 32'h00000009; elo = 32'h11111108;
`endif
    src_1 = 32'h0000ABCD; mthi = 1'b1; mtlo = 1'b1; @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    issue(o, 32'h11111111, 32'h00000088);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; mthi = 1'b1; mtlo = 1'b1; src_1 = 32'h1234; src_2 = 32'h5;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    nvec++; if (hi !== 32'h0000ABCD || lo !== 32'h0000ABCD || busy !== 1'b1) begin nerr++;
      $display("FAIL busy_strobes: hi=%h lo=%h busy=%b required abcd/abcd/1", hi, lo, busy); end
    wait_done(lat);
    nvec++; if (lat !== 28) begin nerr++; $display("FAIL busy_latency: %0d required 28", lat); end
    nvec++; if (hi !== ehi || lo !== elo) begin nerr++;
      $display("FAIL busy_result: hi=%h lo=%h required %h/%h", hi, lo, ehi, elo); end
    @(negedge clk);
    @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL busy_no_restart: busy=%b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'b01, 32'd1000, 32'd1000);
    wait_done(lat);
    nvec++; if (lat !== 33 || hi !== 32'h0 || lo !== 32'd1000000) begin nerr++;
      $display("FAIL b2b_first: lat=%0d hi=%h lo=%h required 33/0/000f4240", lat, hi, lo); end
    issue(2'b00, 32'hFFFFFFFF, 32'd9);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_accept: busy=%b required 1", busy); end
    wait_done(lat);
    nvec++; if (lat !== 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF7) begin nerr++;
      $display("FAIL b2b_second: lat=%0d hi=%h lo=%h required 33/ffffffff/fffffff7", lat, hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    int lat;
    src_1 = 32'h55; mthi = 1'b1; mtlo = 1'b1; @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    issue(2'b01, 32'h11111111, 32'h88);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    nvec++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin nerr++;
      $display("FAIL rstmid_state: busy=%b hi=%h lo=%h done=%b required 0/0/0/0", busy, hi, lo, done); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    nvec++; if (saw_done !== 1'b0) begin nerr++; $display("FAIL rstmid_no_done: seen=%b required 0", saw_done); end
    issue(2'b01, 32'd6, 32'd7);
    wait_done(lat);
    nvec++; if (lat !== 33 || hi !== 32'h0 || lo !== 32'd42) begin nerr++;
      $display("FAIL rstmid_after: lat=%0d hi=%h lo=%h required 33/0/2a", lat, hi, lo); end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 2'b00; src_1 = '0; src_2 = '0; mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    test_reset();
    test_mthi_mtlo();
    test_multiply();
`ifdef MIPS_MULDIV_DIV_EN
    test_divide();
`else
    test_div_disabled();
`endif
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
